bus_arbiter4: RTL and testbench

- Round-robin arbiter that shares one datapath resource, such as a shared bus or ALU input, between four requesters.
- The resource itself is a 4:1 selection tree built from the 2:1 mux primitive.
- The block issues a registered one-hot grant and drives the 2-bit select code for that mux tree.
- A grant is held for as long as the owner keeps requesting; priority rotates after every ownership change.

---
 rtl/bus_arbiter4.sv | 159 +++++++++++++++
 tb/tb_bus_arbiter4.sv | 111 +++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// Four-way round-robin arbiter producing a registered one-hot grant and the select code for a 4:1 mux tree.
// Optional per-owner hold limit is enabled by defining GRANT_TIMEOUT_EN.
module bus_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       busy_q, busy_d;
  logic [3:0] mask_s;
  logic [2:0] win_s;
  logic       forced_s;
`ifdef GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Returns {found, index} of the first set bit of r, scanning p, p+1, ... modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Next-state, grant and pointer computation.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    mask_s   = 4'b0000;
    win_s    = 3'b000;
    forced_s = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        win_s = pick(req, ptr_q);
        if (win_s[2]) begin
          gnt_d   = onehot(win_s[1:0]);
          sel_d   = win_s[1:0];
          state_d = GRANT;
`ifdef GRANT_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
`ifdef GRANT_TIMEOUT_EN
        forced_s = req[sel_q] && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
        if (req[sel_q] && !forced_s) begin
          gnt_d = gnt_q;
`ifdef GRANT_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end else begin
          // The owner is always masked: on a normal release its req is already low.
          ptr_d          = sel_q + 2'd1;
          mask_s         = req;
          mask_s[sel_q]  = 1'b0;
          win_s          = pick(mask_s, sel_q + 2'd1);
          if (win_s[2]) begin
            gnt_d     = onehot(win_s[1:0]);
            sel_d     = win_s[1:0];
            state_d   = GRANT;
`ifdef GRANT_TIMEOUT_EN
            cnt_d     = {CNT_W{1'b0}};
            timeout_d = forced_s;
`endif
          end else if (forced_s) begin
            state_d = GRANT;
`ifdef GRANT_TIMEOUT_EN
            cnt_d   = {CNT_W{1'b0}};
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
    busy_d = |gnt_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      busy_q    <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      cnt_q     <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
`ifdef GRANT_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
`ifdef GRANT_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = TIMEOUT_CYCLES[0] ^ CNT_W[0];
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed self-checking bench for bus_arbiter4; timeout steps run only when GRANT_TIMEOUT_EN is defined.
module tb_bus_arbiter4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;
  int         n_run = 0;
  int         n_fail = 0;

  bus_arbiter4 #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic et);
    logic [7:0] obs;
    logic [7:0] expv;
    obs  = {gnt, sel, busy, timeout};
    expv = {eg, es, eb, et};
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed gnt/sel/busy/timeout=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] nx;
    // Reset held with all requesting
    rst = 1'b1; req = 4'b1111;
    tick(); tick();
    chk("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("first_grant", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Rotation: each owner holds 3 cycles then drops for one cycle
    for (int o = 0; o < 4; o++) begin
      oh = 4'b0001 << o;
      nx = 4'b0001 << ((o + 1) % 4);
      tick(); chk("rot_hold", oh, 2'(o), 1'b1, 1'b0);
      tick(); chk("rot_hold", oh, 2'(o), 1'b1, 1'b0);
      req = 4'b1111 & ~oh;
      tick(); chk("rot_next", nx, 2'((o + 1) % 4), 1'b1, 1'b0);
      req = 4'b1111;
    end

    // Hold and idle: owner 0 releases, requester 2 alone holds 10 cycles
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("hold2", 4'b0100, 2'b10, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick(); chk("idle", 4'b0000, 2'b10, 1'b0, 1'b0);
    tick(); chk("idle2", 4'b0000, 2'b10, 1'b0, 1'b0);
    req = 4'b0101;
    tick(); chk("wrap_from3", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Same-cycle handoff: owner 1 drops as 3 rises, 0 still high -> scan from 2
    req = 4'b0010;
    tick(); chk("to_owner1", 4'b0010, 2'b01, 1'b1, 1'b0);
    req = 4'b1001;
    tick(); chk("handoff", 4'b1000, 2'b11, 1'b1, 1'b0);

    // Reset mid-grant
    req = 4'b0010;
    tick(); chk("pre_rst", 4'b0010, 2'b01, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk("mid_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b0011;
    tick(); chk("post_rst", 4'b0001, 2'b00, 1'b1, 1'b0);

`ifdef GRANT_TIMEOUT_EN
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0; req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("to_hold0", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
    tick(); chk("to_force1", 4'b0010, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("to_hold1", 4'b0010, 2'b01, 1'b1, 1'b0);
    end
    tick(); chk("to_force0", 4'b0001, 2'b00, 1'b1, 1'b1);
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("to_alone", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
`else
    // Without the timeout feature a continuous owner keeps the grant
    req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("no_timeout", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
